// File: rtl/pwm_pkg.sv
// Shared types and default sizing for the multi-channel PWM block.
package pwm_pkg;

   localparam int PWM_NCH_DEF   = 4;
   localparam int PWM_CBITS_DEF = 11;

   typedef enum logic {
      PWM_EDGE   = 1'b0,
      PWM_CENTER = 1'b1
   } pwm_mode_e;

   typedef enum logic [1:0] {
      ST_UP   = 2'd0,
      ST_DOWN = 2'd1,
      ST_HOLD = 2'd2
   } pwm_state_e;

endpackage

// File: rtl/pwm_ch_cmp.sv
// One PWM channel: double-buffered duty (shadow -> active) and the registered
// compare against the shared counter.
module pwm_ch_cmp
   import pwm_pkg::*;
#(
   parameter int CBITS = PWM_CBITS_DEF
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             bnd,
   input  logic             wr_hit,
   input  logic [CBITS-1:0] wr_duty,
   input  logic [CBITS-1:0] cnt,
   output logic             pwm,
   output logic             pending
);

   logic [CBITS-1:0] shadow_q;
   logic [CBITS-1:0] duty_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         shadow_q <= '0;
         duty_q   <= '0;
         pending  <= 1'b0;
         pwm      <= 1'b0;
      end else begin
         pwm <= en && (cnt < duty_q);
         if (wr_hit)
            shadow_q <= wr_duty;
         // While stopped the active duty follows the shadow, including a write landing now.
         if (!en) begin
            duty_q  <= wr_hit ? wr_duty : shadow_q;
            pending <= 1'b0;
         end else begin
            if (bnd && pending)
               duty_q <= shadow_q;
            if (wr_hit)
               pending <= 1'b1;
            else if (bnd)
               pending <= 1'b0;
         end
      end
   end

endmodule

// File: rtl/pwm_multi_ch.sv
// Multi-channel PWM: one shared edge/center-aligned counter with period-boundary
// reload of period, mode and per-channel duties.
module pwm_multi_ch
   import pwm_pkg::*;
#(
   parameter  int NCH   = PWM_NCH_DEF,
   parameter  int CBITS = PWM_CBITS_DEF,
   localparam int CHW   = (NCH > 1) ? $clog2(NCH) : 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             mode,
   input  logic [CBITS-1:0] period,
   input  logic             wr_en,
   input  logic [CHW-1:0]   wr_ch,
   input  logic [CBITS-1:0] wr_duty,
   output logic [NCH-1:0]   pwm_out,
   output logic             period_end,
   output logic [NCH-1:0]   pending
);

   localparam logic [CBITS-1:0] CNT_ONE = CBITS'(1);

   pwm_state_e       st_q, st_d;
   pwm_mode_e        mode_q;
   logic [CBITS-1:0] cnt_q, cnt_d;
   logic [CBITS-1:0] period_q;
   logic             bnd;
   logic [NCH-1:0]   wr_sel;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         st_q       <= ST_HOLD;
         cnt_q      <= '0;
         period_q   <= '0;
         mode_q     <= PWM_EDGE;
         period_end <= 1'b0;
      end else begin
         st_q       <= st_d;
         cnt_q      <= cnt_d;
         period_end <= bnd;
         if (bnd || !en) begin
            period_q <= period;
            mode_q   <= pwm_mode_e'(mode);
         end
      end
   end

   // HOLD parks the counter at 0 and otherwise behaves like UP when counting resumes.
   always_comb begin
      st_d  = st_q;
      cnt_d = cnt_q;
      bnd   = 1'b0;
      if (!en) begin
         st_d  = ST_HOLD;
         cnt_d = '0;
      end else if (period_q == '0) begin
         st_d  = ST_HOLD;
         cnt_d = '0;
         bnd   = 1'b1;
      end else if (st_q == ST_DOWN) begin
         cnt_d = cnt_q - CNT_ONE;
         if (cnt_q == CNT_ONE) begin
            st_d = ST_UP;
            bnd  = 1'b1;
         end
      end else if (cnt_q >= period_q) begin
         if (mode_q == PWM_EDGE || period_q == CNT_ONE) begin
            st_d  = ST_UP;
            cnt_d = '0;
            bnd   = 1'b1;
         end else begin
            st_d  = ST_DOWN;
            cnt_d = period_q - CNT_ONE;
         end
      end else begin
         st_d  = ST_UP;
         cnt_d = cnt_q + CNT_ONE;
      end
   end

   always_comb begin
      wr_sel = '0;
      if (wr_en && (int'(wr_ch) < NCH))
         wr_sel[wr_ch] = 1'b1;
   end

   for (genvar i = 0; i < NCH; i++) begin : g_ch
      pwm_ch_cmp #(
         .CBITS (CBITS)
      ) u_ch (
         .clk     (clk),
         .rst     (rst),
         .en      (en),
         .bnd     (bnd),
         .wr_hit  (wr_sel[i]),
         .wr_duty (wr_duty),
         .cnt     (cnt_q),
         .pwm     (pwm_out[i]),
         .pending (pending[i])
      );
   end

endmodule

// File: tb/tb_pwm_multi_ch.sv
// Scoreboard bench for pwm_multi_ch: a phase-based reference model predicts
// every cycle's outputs; a monitor pops and compares after each clock edge.
module tb_pwm_multi_ch;

   localparam int NCH   = 3;
   localparam int CBITS = 11;

   typedef struct {
      logic [NCH-1:0] pwm;
      logic           pe;
      logic [NCH-1:0] pend;
   } exp_t;

   logic             clk = 1'b0;
   logic             rst;
   logic             en;
   logic             mode;
   logic [CBITS-1:0] period;
   logic             wr_en;
   logic [1:0]       wr_ch;
   logic [CBITS-1:0] wr_duty;
   logic [NCH-1:0]   pwm_out;
   logic             period_end;
   logic [NCH-1:0]   pending;

   pwm_multi_ch #(
      .NCH   (NCH),
      .CBITS (CBITS)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .en         (en),
      .mode       (mode),
      .period     (period),
      .wr_en      (wr_en),
      .wr_ch      (wr_ch),
      .wr_duty    (wr_duty),
      .pwm_out    (pwm_out),
      .period_end (period_end),
      .pending    (pending)
   );

   always #5 clk = ~clk;

   int   checks = 0;
   int   errors = 0;
   exp_t exp_q[$];

   // Reference model: position within the period plus the latched settings.
   int m_phase, m_per;
   bit m_mode;
   int m_duty[NCH], m_shadow[NCH];
   bit m_pend[NCH];

   bit cur_en, cur_mode;
   int cur_per;
   int hi_cnt[NCH];
   int pe_cnt;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%0d required=%0d", nm, act, req);
      end
   endtask

   function automatic int period_len(input int p, input bit md);
      if (p == 0) return 1;
      return md ? 2 * p : p + 1;
   endfunction

   function automatic bit next_is_bnd();
      return cur_en && (m_phase + 1 == period_len(m_per, m_mode));
   endfunction

   function automatic void model_reset();
      m_phase = 0;
      m_per   = 0;
      m_mode  = 1'b0;
      for (int i = 0; i < NCH; i++) begin
         m_duty[i]   = 0;
         m_shadow[i] = 0;
         m_pend[i]   = 1'b0;
      end
   endfunction

   function automatic exp_t model_step(input bit e, input bit md, input int per,
                                       input bit we, input int wc, input int wd);
      exp_t x;
      int   len, cnt;
      bit   bnd, hit;
      len = period_len(m_per, m_mode);
      cnt = (m_mode && m_phase > m_per) ? 2 * m_per - m_phase : m_phase;
      bnd = e && (m_phase + 1 == len);
      x.pe = bnd;
      for (int i = 0; i < NCH; i++) begin
         x.pwm[i] = e && (cnt < m_duty[i]);
         hit = we && (wc == i);
         if (!e) begin
            m_duty[i] = hit ? wd : m_shadow[i];
            m_pend[i] = 1'b0;
         end else begin
            if (bnd && m_pend[i]) m_duty[i] = m_shadow[i];
            if (hit) m_pend[i] = 1'b1;
            else if (bnd) m_pend[i] = 1'b0;
         end
         if (hit) m_shadow[i] = wd;
         x.pend[i] = m_pend[i];
      end
      m_phase = (!e || bnd) ? 0 : m_phase + 1;
      if (!e || bnd) begin
         m_per  = per;
         m_mode = md;
      end
      return x;
   endfunction

   task automatic drive_cycle(input bit we, input int wc, input int wd);
      @(negedge clk);
      for (int i = 0; i < NCH; i++)
         if (pwm_out[i] === 1'b1) hi_cnt[i]++;
      if (period_end === 1'b1) pe_cnt++;
      en      = cur_en;
      mode    = cur_mode;
      period  = CBITS'(cur_per);
      wr_en   = we;
      wr_ch   = 2'(wc);
      wr_duty = CBITS'(wd);
      exp_q.push_back(model_step(cur_en, cur_mode, cur_per, we, wc, wd));
   endtask

   task automatic steady(input int n);
      for (int k = 0; k < n; k++) drive_cycle(1'b0, 0, 0);
   endtask

   task automatic clear_acc();
      for (int i = 0; i < NCH; i++) hi_cnt[i] = 0;
      pe_cnt = 0;
   endtask

   // Runs up to and including the next boundary edge, then clears the window counters.
   task automatic wait_bnd();
      int k;
      k = 0;
      while (!next_is_bnd() && k < 200) begin
         drive_cycle(1'b0, 0, 0);
         k++;
      end
      if (!next_is_bnd()) chk("bnd_timeout", 32'(k), 32'd0);
      drive_cycle(1'b0, 0, 0);
      clear_acc();
   endtask

   initial begin : monitor
      exp_t x;
      forever begin
         @(posedge clk);
         #1;
         if (exp_q.size() > 0) begin
            x = exp_q.pop_front();
            chk("pwm_out", 32'(pwm_out), 32'(x.pwm));
            chk("period_end", 32'(period_end), 32'(x.pe));
            chk("pending", 32'(pending), 32'(x.pend));
         end
      end
   end

   initial begin : watchdog
      #2ms;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin : stimulus
      rst = 1'b1; en = 1'b0; mode = 1'b0; period = '0;
      wr_en = 1'b0; wr_ch = '0; wr_duty = '0;
      cur_en = 1'b0; cur_mode = 1'b0; cur_per = 0;
      model_reset();
      clear_acc();
      repeat (2) @(negedge clk);
      chk("reset_pwm", 32'(pwm_out), 32'd0);
      chk("reset_pe", 32'(period_end), 32'd0);
      chk("reset_pending", 32'(pending), 32'd0);
      rst = 1'b0;

      // Edge mode, period 9, ch0 duty 3 loaded while stopped.
      cur_per = 9;
      drive_cycle(1'b1, 0, 3);
      drive_cycle(1'b0, 0, 0);
      cur_en = 1'b1;
      wait_bnd();
      steady(10);
      chk("edge_hi_ch0", 32'(hi_cnt[0]), 32'd3);
      chk("edge_pe", 32'(pe_cnt), 32'd1);

      // Mid-period write to ch2 is held pending until the next boundary.
      steady(3);
      drive_cycle(1'b1, 2, 7);
      @(posedge clk); #2;
      chk("mid_write_pending", 32'(pending[2]), 32'd1);
      wait_bnd();
      wait_bnd();
      steady(10);
      chk("mid_write_hi_ch2", 32'(hi_cnt[2]), 32'd7);

      // Duty limits: 0 -> always low, period+1 -> always high.
      drive_cycle(1'b1, 0, 0);
      drive_cycle(1'b1, 1, 10);
      wait_bnd();
      wait_bnd();
      steady(10);
      chk("limit_low_ch0", 32'(hi_cnt[0]), 32'd0);
      chk("limit_high_ch1", 32'(hi_cnt[1]), 32'd10);

      // Write landing exactly on the boundary edge.
      for (int k = 0; k < 20 && !next_is_bnd(); k++) drive_cycle(1'b0, 0, 0);
      drive_cycle(1'b1, 2, 5);
      @(posedge clk); #2;
      chk("bnd_write_pending", 32'(pending[2]), 32'd1);
      wait_bnd();
      wait_bnd();
      steady(10);
      chk("bnd_write_hi_ch2", 32'(hi_cnt[2]), 32'd5);

      // Center mode, period 4, ch1 duty 2.
      cur_mode = 1'b1;
      cur_per  = 4;
      drive_cycle(1'b1, 1, 2);
      wait_bnd();
      wait_bnd();
      steady(8);
      chk("center_pe", 32'(pe_cnt), 32'd1);
      steady(8);
      chk("center_pe2", 32'(pe_cnt), 32'd2);

      // Period 0: boundary every cycle.
      cur_per = 0;
      wait_bnd();
      steady(5);
      chk("per0_pe", 32'(pe_cnt), 32'd5);

      // Stop, write while stopped, restart.
      cur_mode = 1'b0;
      cur_per  = 6;
      cur_en   = 1'b0;
      drive_cycle(1'b1, 0, 4);
      drive_cycle(1'b1, 3, 9);
      steady(3);
      cur_en = 1'b1;
      steady(20);

      // Randomized traffic.
      for (int k = 0; k < 3000; k++) begin
         if ($urandom_range(0, 99) < 3) cur_en = ~cur_en;
         if (!cur_en && $urandom_range(0, 99) < 30) cur_en = 1'b1;
         if ($urandom_range(0, 99) < 5) cur_mode = ~cur_mode;
         if ($urandom_range(0, 99) < 8) cur_per = $urandom_range(0, 15);
         if ($urandom_range(0, 99) < 30)
            drive_cycle(1'b1, $urandom_range(0, 3), $urandom_range(0, cur_per + 3));
         else
            drive_cycle(1'b0, 0, 0);
      end

      // Reset mid-period with a channel driving high.
      cur_en = 1'b1; cur_mode = 1'b0; cur_per = 9;
      drive_cycle(1'b1, 0, 10);
      wait_bnd();
      wait_bnd();
      steady(3);
      @(negedge clk);
      chk("pre_reset_high", 32'(pwm_out[0]), 32'd1);
      rst = 1'b1;
      #1;
      chk("async_reset_pwm", 32'(pwm_out), 32'd0);
      chk("async_reset_pe", 32'(period_end), 32'd0);
      chk("async_reset_pending", 32'(pending), 32'd0);
      model_reset();
      @(posedge clk); #2;
      rst = 1'b0;
      steady(25);

      repeat (2) @(posedge clk);
      #2;
      chk("queue_drained", 32'(exp_q.size()), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
